// File: rtl/scan_display_ctrl.sv
// Multiplexed 7-segment scan controller with a tear-free pending/shadow update path.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module scan_display_ctrl #(
   parameter int N_DIGITS = 4,
   parameter int DIV      = 100000,
   parameter int HEX_MODE = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [4*N_DIGITS-1:0] data_in,
   input  logic [N_DIGITS-1:0]   dp_in,
   input  logic                  load,
   output logic                  upd_done,
   output logic                  pending,
   output logic [6:0]            leds,
   output logic                  dp,
   output logic [N_DIGITS-1:0]   an
);

   localparam int CW = $clog2(DIV);
   localparam int IW = $clog2(N_DIGITS);
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
   localparam logic [IW-1:0] IDX_MAX = IW'(N_DIGITS - 1);

   logic [CW-1:0]         cnt;
   logic [IW-1:0]         idx;
   logic                  tick, frame_end;
   logic [4*N_DIGITS-1:0] pend_data, shadow;
   logic [N_DIGITS-1:0]   pend_dp, shadow_dp;
   logic [3:0]            nib;
   logic [N_DIGITS-1:0]   an_nxt;
   logic                  dp_nxt, blk;
   logic [6:0]            leds_nxt;

   function automatic logic [6:0] seg7(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'b0111111;
         4'h1: s = 7'b0000110;
         4'h2: s = 7'b1011011;
         4'h3: s = 7'b1001111;
         4'h4: s = 7'b1100110;
         4'h5: s = 7'b1101101;
         4'h6: s = 7'b1111101;
         4'h7: s = 7'b0000111;
         4'h8: s = 7'b1111111;
         4'h9: s = 7'b1101111;
         4'hA: s = 7'b1110111;
         4'hB: s = 7'b1111100;
         4'hC: s = 7'b0111001;
         4'hD: s = 7'b1011110;
         4'hE: s = 7'b1111001;
         default: s = 7'b1110001;
      endcase
      if (v > 4'h9 && HEX_MODE == 0) s = 7'b0000000;
      return s;
   endfunction

   assign tick      = en && (cnt == CNT_MAX);
   assign frame_end = tick && (idx == IDX_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         idx <= '0;
      end else if (en) begin
         cnt <= tick ? '0 : cnt + 1'b1;
         if (tick) idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end
   end

   // A load coinciding with frame_end still lands in pending; the older data transfers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_data <= '0;
         pend_dp   <= '0;
         pending   <= 1'b0;
         shadow    <= '0;
         shadow_dp <= '0;
         upd_done  <= 1'b0;
      end else begin
         upd_done <= frame_end && pending;
         if (frame_end && pending) begin
            shadow    <= pend_data;
            shadow_dp <= pend_dp;
         end
         if (load) begin
            pend_data <= data_in;
            pend_dp   <= dp_in;
            pending   <= 1'b1;
         end else if (frame_end) begin
            pending <= 1'b0;
         end
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic [N_DIGITS-1:0] lz;
   logic                zrun;
   // lz[j] set when nibble j and every nibble left of it are zero; rightmost never blanks.
   always_comb begin
      lz   = '0;
      zrun = 1'b1;
      for (int j = N_DIGITS - 1; j > 0; j--) begin
         zrun  = zrun && (shadow[4*j+3 -: 4] == 4'd0);
         lz[j] = zrun;
      end
   end
`endif

   always_comb begin
      nib    = '0;
      an_nxt = '0;
      dp_nxt = 1'b0;
      blk    = 1'b0;
      for (int k = 0; k < N_DIGITS; k++) begin
         if (idx == IW'(k)) begin
            an_nxt[N_DIGITS-1-k] = 1'b1;
            nib    = shadow[4*(N_DIGITS-k)-1 -: 4];
            dp_nxt = shadow_dp[N_DIGITS-1-k];
`ifdef LEADING_ZERO_BLANK_EN
            blk    = lz[N_DIGITS-1-k];
`endif
         end
      end
      leds_nxt = blk ? 7'b0000000 : seg7(nib);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         leds <= '0;
         dp   <= 1'b0;
         an   <= '0;
      end else if (!en) begin
         leds <= '0;
         dp   <= 1'b0;
         an   <= '0;
      end else begin
         leds <= leds_nxt;
         dp   <= dp_nxt;
         an   <= an_nxt;
      end
   end

endmodule

// File: tb/tb_scan_display_ctrl.sv
// Directed bench for scan_display_ctrl (N_DIGITS=4, DIV=4); HEX_MODE=1 and HEX_MODE=0 instances share stimulus.
module tb_scan_display_ctrl;

   logic        clk = 1'b0;
   logic        rst, en, load;
   logic [15:0] data_in;
   logic [3:0]  dp_in;
   logic        upd1, pend1, dp1, upd0, pend0, dp0;
   logic [6:0]  leds1, leds0;
   logic [3:0]  an1, an0;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   scan_display_ctrl #(.N_DIGITS(4), .DIV(4), .HEX_MODE(1)) u_hex (
      .clk(clk), .rst(rst), .en(en), .data_in(data_in), .dp_in(dp_in), .load(load),
      .upd_done(upd1), .pending(pend1), .leds(leds1), .dp(dp1), .an(an1));

   scan_display_ctrl #(.N_DIGITS(4), .DIV(4), .HEX_MODE(0)) u_dec (
      .clk(clk), .rst(rst), .en(en), .data_in(data_in), .dp_in(dp_in), .load(load),
      .upd_done(upd0), .pending(pend0), .leds(leds0), .dp(dp0), .an(an0));

   function automatic logic [6:0] ref_seg(input logic [3:0] v, input bit hex);
      case (v)
         4'h0: return 7'b0111111;
         4'h1: return 7'b0000110;
         4'h2: return 7'b1011011;
         4'h3: return 7'b1001111;
         4'h4: return 7'b1100110;
         4'h5: return 7'b1101101;
         4'h6: return 7'b1111101;
         4'h7: return 7'b0000111;
         4'h8: return 7'b1111111;
         4'h9: return 7'b1101111;
         4'hA: return hex ? 7'b1110111 : 7'b0000000;
         4'hB: return hex ? 7'b1111100 : 7'b0000000;
         4'hC: return hex ? 7'b0111001 : 7'b0000000;
         4'hD: return hex ? 7'b1011110 : 7'b0000000;
         4'hE: return hex ? 7'b1111001 : 7'b0000000;
         default: return hex ? 7'b1110001 : 7'b0000000;
      endcase
   endfunction

   // d = 0 is the leftmost digit
   function automatic logic [6:0] ref_digit(input logic [15:0] val, input int d, input bit hex);
      logic [15:0] sh;
      sh = val >> (4 * (3 - d));
`ifdef LEADING_ZERO_BLANK_EN
      if (d < 3 && sh == 16'h0) return 7'b0000000;
`endif
      return ref_seg(sh[3:0], hex);
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_upd(input string nm);
      bit seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         step();
         seen = upd1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s: upd_done timeout got=0 exp=1", nm);
      end
   endtask

   // Starts on the first sample of a frame (idx 0 shown) and ends on the next frame's first sample.
   task automatic check_frame(input logic [15:0] val, input logic [3:0] dpv, input bit upd_end,
                              input string nm);
      logic [3:0] ea;
      logic [6:0] e1, e0;
      for (int d = 0; d < 4; d++) begin
         ea = 4'b1000 >> d;
         e1 = ref_digit(val, d, 1'b1);
         e0 = ref_digit(val, d, 1'b0);
         for (int r = 0; r < 4; r++) begin
            checks += 5;
            if (an1 !== ea) begin
               errors++; $display("FAIL %s an d%0d r%0d got=%b exp=%b", nm, d, r, an1, ea);
            end
            if (an0 !== ea) begin
               errors++; $display("FAIL %s an_dec d%0d r%0d got=%b exp=%b", nm, d, r, an0, ea);
            end
            if (leds1 !== e1) begin
               errors++; $display("FAIL %s leds d%0d r%0d got=%b exp=%b", nm, d, r, leds1, e1);
            end
            if (leds0 !== e0) begin
               errors++; $display("FAIL %s leds_dec d%0d r%0d got=%b exp=%b", nm, d, r, leds0, e0);
            end
            if (dp1 !== dpv[3-d]) begin
               errors++; $display("FAIL %s dp d%0d r%0d got=%b exp=%b", nm, d, r, dp1, dpv[3-d]);
            end
            if (d == 3 && r == 3) begin
               checks++;
               if (upd1 !== upd_end) begin
                  errors++; $display("FAIL %s upd_end got=%b exp=%b", nm, upd1, upd_end);
               end
            end
            step();
         end
      end
   endtask

   task automatic load_word(input logic [15:0] v, input logic [3:0] d);
      data_in = v;
      dp_in   = d;
      load    = 1'b1;
      step();
      load    = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; en = 1'b1; load = 1'b0; data_in = '0; dp_in = '0;
      repeat (3) @(posedge clk);
      #1;
      checks += 4;
      if (leds1 !== 7'd0) begin errors++; $display("FAIL reset leds got=%b exp=0", leds1); end
      if (an1 !== 4'd0)   begin errors++; $display("FAIL reset an got=%b exp=0", an1); end
      if (pend1 !== 1'b0) begin errors++; $display("FAIL reset pending got=%b exp=0", pend1); end
      if (upd1 !== 1'b0)  begin errors++; $display("FAIL reset upd_done got=%b exp=0", upd1); end
      rst = 1'b0;
      step();
      check_frame(16'h0000, 4'h0, 1'b0, "reset_frame");
   endtask

   task automatic test_scan;
      load_word(16'h1234, 4'b0101);
      checks++;
      if (pend1 !== 1'b1) begin errors++; $display("FAIL scan pending got=%b exp=1", pend1); end
      wait_upd("scan");
      checks++;
      if (pend1 !== 1'b0) begin errors++; $display("FAIL scan pending_clr got=%b exp=0", pend1); end
      step();
      check_frame(16'h1234, 4'b0101, 1'b0, "scan");
   endtask

   task automatic test_tear_free;
      logic [6:0] e;
      repeat (5) step();
      load_word(16'h5678, 4'b1000);
      checks++;
      if (pend1 !== 1'b1) begin errors++; $display("FAIL tear pending got=%b exp=1", pend1); end
      for (int p = 6; p < 16; p++) begin
         e = ref_digit(16'h1234, p / 4, 1'b1);
         checks += 2;
         if (leds1 !== e) begin
            errors++; $display("FAIL tear hold pos%0d got=%b exp=%b", p, leds1, e);
         end
         if (upd1 !== (p == 15)) begin
            errors++; $display("FAIL tear upd pos%0d got=%b exp=%b", p, upd1, (p == 15));
         end
         step();
      end
      checks++;
      if (leds1 !== 7'b1101101) begin errors++; $display("FAIL tear first5 got=%b exp=1101101", leds1); end
      check_frame(16'h5678, 4'b1000, 1'b0, "tear_new");
   endtask

   task automatic test_collision;
      repeat (14) step();
      data_in = 16'h9087; dp_in = 4'b0011; load = 1'b1;
      step();
      load = 1'b0;
      checks += 2;
      if (upd1 !== 1'b0)  begin errors++; $display("FAIL collide upd got=%b exp=0", upd1); end
      if (pend1 !== 1'b1) begin errors++; $display("FAIL collide pending got=%b exp=1", pend1); end
      step();
      check_frame(16'h5678, 4'b1000, 1'b1, "collide_old");
      check_frame(16'h9087, 4'b0011, 1'b0, "collide_new");
   endtask

   task automatic test_back_to_back;
      data_in = 16'hAAAA; dp_in = 4'b1111; load = 1'b1;
      step();
      data_in = 16'h0042; dp_in = 4'b0010;
      step();
      load = 1'b0;
      wait_upd("b2b");
      step();
      check_frame(16'h0042, 4'b0010, 1'b0, "b2b");
   endtask

   task automatic test_hex;
      load_word(16'hABCF, 4'b0000);
      wait_upd("hex");
      step();
      check_frame(16'hABCF, 4'b0000, 1'b0, "hex");
   endtask

   task automatic test_blank;
      load_word(16'h0040, 4'b0100);
      wait_upd("blank40");
      step();
      check_frame(16'h0040, 4'b0100, 1'b0, "blank40");
      load_word(16'h0000, 4'b0000);
      wait_upd("blank00");
      step();
      check_frame(16'h0000, 4'b0000, 1'b0, "blank00");
   endtask

   task automatic test_en;
      repeat (5) step();
      en = 1'b0;
      load_word(16'h0007, 4'b0001);
      checks += 4;
      if (an1 !== 4'd0)   begin errors++; $display("FAIL en_off an got=%b exp=0000", an1); end
      if (leds1 !== 7'd0) begin errors++; $display("FAIL en_off leds got=%b exp=0", leds1); end
      if (dp1 !== 1'b0)   begin errors++; $display("FAIL en_off dp got=%b exp=0", dp1); end
      if (pend1 !== 1'b1) begin errors++; $display("FAIL en_off pending got=%b exp=1", pend1); end
      for (int i = 0; i < 3; i++) begin
         step();
         checks += 2;
         if (an1 !== 4'd0) begin errors++; $display("FAIL en_hold an got=%b exp=0000", an1); end
         if (upd1 !== 1'b0) begin errors++; $display("FAIL en_hold upd got=%b exp=0", upd1); end
      end
      en = 1'b1;
      step();
      checks++;
      if (an1 !== 4'b0100) begin errors++; $display("FAIL en_resume0 an got=%b exp=0100", an1); end
      step();
      checks++;
      if (an1 !== 4'b0100) begin errors++; $display("FAIL en_resume1 an got=%b exp=0100", an1); end
      step();
      checks++;
      if (an1 !== 4'b0010) begin errors++; $display("FAIL en_resume2 an got=%b exp=0010", an1); end
      wait_upd("en");
      step();
      check_frame(16'h0007, 4'b0001, 1'b0, "en_new");
   endtask

   task automatic test_reset_mid;
      load_word(16'h1111, 4'b1111);
      repeat (3) step();
      rst = 1'b1;
      #1;
      checks += 5;
      if (leds1 !== 7'd0) begin errors++; $display("FAIL rstmid leds got=%b exp=0", leds1); end
      if (an1 !== 4'd0)   begin errors++; $display("FAIL rstmid an got=%b exp=0000", an1); end
      if (dp1 !== 1'b0)   begin errors++; $display("FAIL rstmid dp got=%b exp=0", dp1); end
      if (pend1 !== 1'b0) begin errors++; $display("FAIL rstmid pending got=%b exp=0", pend1); end
      if (upd1 !== 1'b0)  begin errors++; $display("FAIL rstmid upd got=%b exp=0", upd1); end
      step();
      rst = 1'b0;
      step();
      check_frame(16'h0000, 4'b0000, 1'b0, "rstmid_frame");
   endtask

   initial begin
      test_reset();
      test_scan();
      test_tear_free();
      test_collision();
      test_back_to_back();
      test_hex();
      test_blank();
      test_en();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
